fp32_mac_drain: RTL and testbench



---
 rtl/fp32_mac_drain.sv | 121 ++++++++++++
 tb/tb_fp32_mac_drain.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mac_drain.sv
// Purpose : per-column drain after the FP32 MAC; counts beats, buffers the final beat of each K-length dot product, pulses clr_acc.
// Latency : a final beat is visible on out_data one cycle after its edge; clr_acc pulses in that same following cycle.
// Backpressure: none towards the MAC; a final beat arriving at a full FIFO (with no pop) is dropped and sets sticky ovf.
//
// Ports: clk/rst_n (async active-low), soft_clr (sync clear, highest priority),
//        k_len (beats per dot product, 0 means 1), mac_valid/mac_y (MAC result beat),
//        clr_acc (one-cycle accumulator clear to the MAC), out_valid/out_ready/out_data
//        (FWFT result stream, data 0 when empty), level (occupancy 0..DEPTH), ovf (sticky drop flag).
module fp32_mac_drain #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_clr,
  input  logic [CNT_W-1:0]         k_len,
  input  logic                     mac_valid,
  input  logic [31:0]              mac_y,
  output logic                     clr_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] k_eff;
  logic             beat_final;
  logic             clr_acc_q, clr_acc_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop, push_ok, drop, full;
  logic [31:0]      mem_q [DEPTH];

  always_comb begin
    // k_len is sampled only on the first beat of a dot product; mid-group
    // beats keep using the latched length.
    k_eff = k_q;
    if (cnt_q == '0) begin
      k_eff = (k_len == '0) ? CNT_W'(1) : k_len;
    end
    beat_final = mac_valid && (cnt_q == k_eff - CNT_W'(1));

    push    = beat_final && !soft_clr;
    pop     = (level_q != '0) && out_ready;
    full    = (level_q == FULL_LVL);
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    cnt_d     = cnt_q;
    k_d       = k_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q | drop;
    clr_acc_d = beat_final;

    if (mac_valid) begin
      k_d   = k_eff;
      cnt_d = beat_final ? '0 : cnt_q + CNT_W'(1);
    end
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (soft_clr) begin
      cnt_d     = '0;
      k_d       = k_q;
      wptr_d    = '0;
      rptr_d    = '0;
      level_d   = '0;
      ovf_d     = 1'b0;
      clr_acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      k_q       <= CNT_W'(1);
      clr_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      clr_acc_q <= clr_acc_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset: out_data is masked to 0 whenever level is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= mac_y;
  end

  assign clr_acc   = clr_acc_q;
  assign ovf       = ovf_q;
  assign level     = level_q;
  assign out_valid = (level_q != '0);
  assign out_data  = (level_q != '0) ? mem_q[rptr_q] : 32'h0;

endmodule

// File: tb/tb_fp32_mac_drain.sv
module tb_fp32_mac_drain;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             soft_clr;
  logic [CNT_W-1:0] k_len;
  logic             mac_valid;
  logic [31:0]      mac_y;
  logic             clr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [2:0]       level;
  logic             ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp32_mac_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_clr  (soft_clr),
    .k_len     (k_len),
    .mac_valid (mac_valid),
    .mac_y     (mac_y),
    .clr_acc   (clr_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] y);
    mac_valid = 1'b1;
    mac_y     = y;
    step();
    mac_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [31:0] vals [3];
  int idx;
  int pushed;

  initial begin
    rst_n     = 1'b0;
    soft_clr  = 1'b0;
    k_len     = '0;
    mac_valid = 1'b0;
    mac_y     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clr", clr_acc, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_lvl", level, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();

    // Basic K=4 with a ready consumer
    k_len = 4;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(i);
      chk("k4_clr", clr_acc, (i % 4 == 0) ? 1 : 0);
      chk("k4_lvl", level, (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) chk("k4_dat", out_data, i);
    end
    step();
    chk("k4_clr_end", clr_acc, 0);
    chk("k4_lvl_end", level, 0);
    chk("k4_ovf", ovf, 0);
    out_ready = 1'b0;

    // K=0 behaves as K=1
    k_len = 0;
    for (int i = 0; i < 3; i++) begin
      beat(21 + i);
      chk("k0_clr", clr_acc, 1);
    end
    chk("k0_lvl", level, 3);
    pop_chk("k0_d0", 21);
    pop_chk("k0_d1", 22);
    pop_chk("k0_d2", 23);
    chk("k0_lvl_end", level, 0);

    // k_len change mid-group takes effect at the next boundary
    k_len = 4;
    beat(31); chk("kc_clr1", clr_acc, 0);
    beat(32); chk("kc_clr2", clr_acc, 0);
    k_len = 2;
    beat(33); chk("kc_clr3", clr_acc, 0);
    beat(34); chk("kc_clr4", clr_acc, 1);
    beat(35); chk("kc_clr5", clr_acc, 0);
    beat(36); chk("kc_clr6", clr_acc, 1);
    chk("kc_lvl", level, 2);
    pop_chk("kc_d0", 34);
    pop_chk("kc_d1", 36);

    // Overflow with a stalled consumer
    k_len = 1;
    for (int i = 0; i < 6; i++) begin
      beat(10 + i);
      if (i == 3) begin
        chk("ov_lvl4", level, 4);
        chk("ov_ovf4", ovf, 0);
      end
      if (i == 4) begin
        chk("ov_lvl5", level, 4);
        chk("ov_ovf5", ovf, 1);
      end
      if (i == 5) chk("ov_clr6", clr_acc, 1);
    end
    pop_chk("ov_d0", 10);
    pop_chk("ov_d1", 11);
    pop_chk("ov_d2", 12);
    pop_chk("ov_d3", 13);
    chk("ov_vld_end", out_valid, 0);
    chk("ov_dat_end", out_data, 0);
    chk("ov_sticky", ovf, 1);
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    chk("ov_sc_ovf", ovf, 0);
    chk("ov_sc_clr", clr_acc, 1);
    step();
    chk("ov_sc_clr2", clr_acc, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) beat(40 + i);
    chk("fp_lvl_full", level, 4);
    mac_valid = 1'b1;
    mac_y     = 32'h3F80_0000;
    out_ready = 1'b1;
    step();
    mac_valid = 1'b0;
    out_ready = 1'b0;
    chk("fp_lvl", level, 4);
    chk("fp_ovf", ovf, 0);
    pop_chk("fp_d0", 41);
    pop_chk("fp_d1", 42);
    pop_chk("fp_d2", 43);
    pop_chk("fp_d3", 32'h3F80_0000);
    chk("fp_lvl_end", level, 0);

    // Asynchronous reset in the middle of a 4-beat group
    k_len = 1;
    beat(32'h99);
    k_len = 4;
    beat(50);
    beat(51);
    chk("ar_lvl_pre", level, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_lvl", level, 0);
    chk("ar_vld", out_valid, 0);
    chk("ar_dat", out_data, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_clr", clr_acc, 0);
    #2 rst_n = 1'b1;
    beat(60); chk("ar_clr1", clr_acc, 0);
    beat(61); chk("ar_clr2", clr_acc, 0);
    beat(62); chk("ar_clr3", clr_acc, 0);
    beat(63); chk("ar_clr4", clr_acc, 1);
    chk("ar_lvl_post", level, 1);
    pop_chk("ar_d0", 63);
    chk("ar_lvl_end", level, 0);

    // soft_clr with 3 buffered entries and a beat in the same cycle
    k_len = 1;
    beat(70);
    beat(71);
    beat(72);
    chk("sc_lvl_pre", level, 3);
    soft_clr  = 1'b1;
    mac_valid = 1'b1;
    mac_y     = 32'h77;
    step();
    soft_clr  = 1'b0;
    mac_valid = 1'b0;
    chk("sc_lvl", level, 0);
    chk("sc_vld", out_valid, 0);
    chk("sc_ovf", ovf, 0);
    chk("sc_clr", clr_acc, 1);
    step();
    chk("sc_lvl2", level, 0);
    chk("sc_clr2", clr_acc, 0);

    // Payload integrity under random consumer stalls
    vals[0] = 32'h7FC0_0001;
    vals[1] = 32'hFF80_0000;
    vals[2] = 32'h0000_0001;
    idx     = 0;
    pushed  = 0;
    k_len   = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pushed < 3) begin
        mac_valid = 1'b1;
        mac_y     = vals[pushed];
        pushed++;
      end else begin
        mac_valid = 1'b0;
      end
      out_ready = (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready && idx < 3) begin
        chk("pl_dat", out_data, vals[idx]);
        idx++;
      end
      step();
    end
    mac_valid = 1'b0;
    out_ready = 1'b0;
    chk("pl_cnt", idx, 3);
    chk("pl_lvl_end", level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
